// File: rtl/bft_client_pkg.sv
// ============================================================================
// Module  : bft_client_pkg
// Purpose : Shared pattern codes, LFSR taps, FSM encoding and flit field helpers
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bft_client_pkg;

    localparam int PAT_RANDOM  = 0;
    localparam int PAT_LOCAL   = 1;
    localparam int PAT_BITREV  = 2;
    localparam int PAT_TORNADO = 3;

    // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int flit_dst_lsb(input int d_w);
        return d_w;
    endfunction

    function automatic int flit_src_lsb(input int d_w, input int a_w);
        return d_w - a_w;
    endfunction

    function automatic int flit_seq_w(input int d_w, input int a_w);
        return d_w - a_w;
    endfunction

    function automatic int bitrev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            if (((v >> i) & 1) != 0) begin
                r = r | (1 << (bits - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bft_lfsr16.sv
// ============================================================================
// Module  : bft_lfsr16
// Purpose : 16-bit Galois LFSR with step enable; a zero seed is forced to 1
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bft_lfsr16
    import bft_client_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr
);

    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED_NZ;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/bft_traffic_client.sv
// ============================================================================
// Module  : bft_traffic_client
// Purpose : LFSR-driven BFT leaf traffic injector with backlog plus receive
//           checker. Optional BFT_CLIENT_SEQCHK_EN adds per-source order check.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bft_traffic_client
    import bft_client_pkg::*;
#(
    parameter int          N     = 8,
    parameter int          D_W   = 32,
    parameter int          A_W   = $clog2(N) + 1,
    parameter int          PAT   = 0,
    parameter int          RATE  = 10,
    parameter int          LIMIT = 16,
    parameter int          SIGMA = 4,
    parameter int          POSX  = 0,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_W+D_W:0]     c_i,
    input  logic                 c_i_v,
    output logic                 c_i_bp,
    output logic [A_W+D_W:0]     c_o,
    output logic                 c_o_v,
    input  logic                 c_o_bp,
    output logic [31:0]          sent_cnt,
    output logic [31:0]          recv_cnt,
    output logic                 err,
    output logic                 done
);

    localparam int             LOG_N     = $clog2(N);
    localparam int             FW        = A_W + D_W + 1;
    localparam int             S_W       = flit_seq_w(D_W, A_W);
    localparam int             DST_LSB   = flit_dst_lsb(D_W);
    localparam int             SRC_LSB   = flit_src_lsb(D_W, A_W);
    localparam logic [8:0]     THRESH    = 9'((RATE * 256) / 100);
    localparam logic [15:0]    LFSR_SEED = SEED ^ 16'(POSX + 1);
    localparam logic [A_W-1:0] POSX_A    = A_W'(POSX);
    localparam logic [31:0]    LIMIT_C   = 32'(LIMIT);
    localparam int             FIXED_DST = (PAT == PAT_BITREV) ? bitrev(POSX, LOG_N)
                                                               : ((POSX + N/2 - 1) & (N - 1));
    localparam bit             FIXED_SELF = ((PAT == PAT_BITREV) || (PAT == PAT_TORNADO))
                                            && (FIXED_DST == POSX);

    state_t         state_q, state_d;
    logic [31:0]    attempts_q, attempts_d;
    logic [31:0]    issued_q, issued_d;
    logic [31:0]    sent_q, sent_d;
    logic [31:0]    recv_q, recv_d;
    logic [FW-1:0]  c_o_q, c_o_d;
    logic           c_o_v_q, c_o_v_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    logic [15:0]    lfsr;
    logic [7:0]     r;
    int             dst_int;
    logic [A_W-1:0] new_dst;
    logic           attempt, accept, issue, self_skip;
    logic [31:0]    pending;

    logic [A_W-1:0] rx_dst, rx_src;
    logic [S_W-1:0] rx_seq;
    logic           rx_bad, seq_bad;
    logic           unused_bits;

    bft_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_RUN),
        .lfsr (lfsr)
    );

    always_comb begin
        r       = lfsr[15:8];
        dst_int = FIXED_DST;
        if (PAT == PAT_RANDOM) begin
            dst_int = int'(r) & (N - 1);
        end else if (PAT == PAT_LOCAL) begin
            dst_int = POSX + (int'(r) & (SIGMA - 1)) - SIGMA/2;
            if (dst_int < 0) begin
                dst_int = 0;
            end else if (dst_int > N - 1) begin
                dst_int = N - 1;
            end
        end
        if (((PAT == PAT_RANDOM) || (PAT == PAT_LOCAL)) && (dst_int == POSX)) begin
            dst_int = (POSX + 1) & (N - 1);
        end
        new_dst = A_W'(dst_int);
    end

    // issued_q counts flits loaded (or self-skipped), so it is also the next sequence number
    always_comb begin
        attempt   = (state_q == ST_RUN) && ({1'b0, lfsr[7:0]} < THRESH) && (attempts_q < LIMIT_C);
        accept    = c_o_v_q && !c_o_bp;
        pending   = attempts_q - issued_q + 32'(attempt);
        issue     = (pending != 32'd0) && (!c_o_v_q || accept);
        self_skip = issue && FIXED_SELF;

        attempts_d = attempts_q + 32'(attempt);
        issued_d   = issued_q + 32'(issue);
        sent_d     = sent_q + 32'(accept) + 32'(self_skip);

        c_o_d   = c_o_q;
        c_o_v_d = c_o_v_q && !accept;
        if (issue && !FIXED_SELF) begin
            c_o_v_d = 1'b1;
            c_o_d   = {1'b0, new_dst, POSX_A, S_W'(issued_q)};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (attempts_q == LIMIT_C) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if ((sent_q == LIMIT_C) && !c_o_v_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_DONE);
    end

    assign rx_dst = c_i[DST_LSB +: A_W];
    assign rx_src = c_i[SRC_LSB +: A_W];
    assign rx_seq = c_i[S_W-1:0];

`ifdef BFT_CLIENT_SEQCHK_EN
    logic [S_W-1:0]   exp_q [N];
    logic [S_W-1:0]   exp_d [N];
    logic [LOG_N-1:0] rx_idx;

    assign rx_idx = rx_src[LOG_N-1:0];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            exp_d[i] = exp_q[i];
        end
        seq_bad = 1'b0;
        if (c_i_v) begin
            seq_bad        = (rx_seq != exp_q[rx_idx]);
            exp_d[rx_idx]  = rx_seq + S_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_q[i] <= exp_d[i];
            end
        end
    end
`else
    assign seq_bad = 1'b0;
`endif

    always_comb begin
        rx_bad = c_i_v && ((rx_dst != POSX_A) || (rx_src == POSX_A));
        err_d  = err_q | rx_bad | seq_bad;
        // A self-targeted flit is delivered locally: sent and received in one step
        recv_d = recv_q + 32'(c_i_v) + 32'(self_skip);
    end

    assign unused_bits = ^{c_i[FW-1], rx_seq, r};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            attempts_q <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            recv_q     <= '0;
            c_o_q      <= '0;
            c_o_v_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            attempts_q <= attempts_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            recv_q     <= recv_d;
            c_o_q      <= c_o_d;
            c_o_v_q    <= c_o_v_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign c_i_bp   = 1'b0;
    assign c_o      = c_o_q;
    assign c_o_v    = c_o_v_q;
    assign sent_cnt = sent_q;
    assign recv_cnt = recv_q;
    assign err      = err_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: doc/bft_traffic_client.md
# bft_traffic_client

Synthesizable, parametrised traffic generator and receive checker for one leaf port of the BFT (butterfly fat tree) network. It replaces simulation-only random injection with an LFSR-driven injector. The injector has a backlog counter, so offered load is independent of backpressure. It supports four destination patterns and a valid/backpressure output handshake. On the receive side it counts and checks packets, and it reports sticky errors and a completion flag for the top-level testbench or on-chip BIST.

## Interface
- `N`, 8: number of clients; power of two, ≥2.
- `D_W`, 32: data width.
- `A_W`, $clog2(N)+1: address width.
- `PAT`, 0: destination pattern. 0 = RANDOM, 1 = LOCAL, 2 = BITREV, 3 = TORNADO.
- `RATE`, 10: injection rate in percent, 0..100.
- `LIMIT`, 16: packets to send, ≥1.
- `SIGMA`, 4: LOCAL pattern radius, power of two.
- `POSX`, 0: this client's address.
- `SEED`, 16'hACE1: LFSR seed base.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `start` in 1: level; injection runs while high.
- `c_i` in A_W+D_W+1: received flit.
- `c_i_v` in 1: received flit valid.
- `c_i_bp` out 1: constant 0; the client always sinks.
- `c_o` out A_W+D_W+1: outgoing flit.
- `c_o_v` out 1: outgoing valid.
- `c_o_bp` in 1: network backpressure.
- `sent_cnt` out 32: flits accepted by the network.
- `recv_cnt` out 32: flits received.
- `err` out 1: sticky receive error.
- `done` out 1: all LIMIT packets sent and the output is idle.

## Operation
- Flit layout:
  - `c_o[A_W+D_W]` = 0.
  - `c_o[A_W+D_W-1:D_W]` = destination.
  - `c_o[D_W-1:D_W-A_W]` = POSX.
  - `c_o[D_W-A_W-1:0]` = sequence number, 0..LIMIT-1.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Reset value is SEED^(POSX+1); if that is 0, use 1. The LFSR steps every cycle while state is RUN.
- Attempt: in RUN, an attempt occurs when `lfsr[7:0] < (RATE*256)/100` and `attempts < LIMIT`. RATE=100 attempts every cycle; RATE=0 never attempts.
- Backlog: `backlog = attempts - sent`. An attempt and an accept in the same cycle leave backlog unchanged.
- Destination is computed when a flit is loaded, with r = lfsr[15:8]:
  - RANDOM: r & (N-1).
  - LOCAL: POSX + (r & (SIGMA-1)) - SIGMA/2, clamped to 0..N-1.
  - BITREV: POSX bit-reversed over log2(N) bits.
  - TORNADO: (POSX + N/2 - 1) & (N-1).
  - Self-avoidance, RANDOM and LOCAL only: if the result equals POSX, use (POSX+1)&(N-1).
  - BITREV and TORNADO self-targets are counted as sent but never driven (`c_o_v` stays 0); they increment `sent_cnt` and `recv_cnt` together.
- State machine:
  - IDLE → RUN on `start`=1.
  - RUN → DRAIN when `attempts==LIMIT`.
  - DRAIN → DONE when `sent==LIMIT` and `c_o_v==0`.
  - Any state → IDLE on `start`=0 from RUN; counters are held.
  - DONE is exited only by reset.
- Output handshake:
  - A flit transfers on a rising edge where `c_o_v=1` and `c_o_bp=0`.
  - While `c_o_bp=1`, `c_o` and `c_o_v` hold stable.
  - A new flit loads in the same edge as an accept if backlog remains.
- Receive path: each `c_i_v=1` cycle increments `recv_cnt`. `err` is set if the destination field ≠ POSX or the source field = POSX.

## Timing
- Reset values: `c_o`=0, `c_o_v`=0, `sent_cnt`=0, `recv_cnt`=0, `err`=0, `done`=0, state IDLE.
- First attempt can occur in the cycle after `start` rises. `c_o_v` rises one cycle after the attempt.
- Throughput: 1 flit/cycle when `c_o_bp`=0.
- `done` is registered and rises one cycle after DRAIN→DONE.
- `recv_cnt` and `err` update one cycle after `c_i_v`.
- Reset asserted mid-packet drops the flit; all state returns to reset values immediately.

## Configuration
- `BFT_CLIENT_SEQCHK_EN`:
  - Defined: N per-source expected-sequence registers (D_W-A_W bits each). A received sequence ≠ expected sets `err`; expected then advances to received+1.
  - Undefined: no per-source registers and no order check; only the address checks apply.

## Structure
- Package `bft_client_pkg`: pattern constants (PAT_RANDOM..PAT_TORNADO), the LFSR polynomial, state encoding, and flit field offset functions.
- Sub-module `bft_lfsr16`: step enable and seed parameter.
- Everything else stays in the top level.

## Test plan
- N=8, POSX=0, PAT=TORNADO, RATE=100, LIMIT=4, `c_o_bp`=0 → 4 flits to dest 3 on consecutive cycles, seq 0..3, `done`=1 two cycles after the last flit.
- As above with `c_o_bp`=1 for cycles 2–6 → `c_o` stable while backpressured, all 4 delivered in order, `sent_cnt`=4.
- RANDOM, RATE=50, LIMIT=16, POSX=2, random `c_o_bp` → no dest 2, `sent_cnt`=16, backlog never negative, `done` asserted.
- Inject `c_i` with dest=POSX and src≠POSX ×3, then one flit with dest≠POSX → `recv_cnt`=4, `err` rises after the fourth.
- With BFT_CLIENT_SEQCHK_EN: from src 1, send seq 0,1,3 → `err` set on seq 3. Without the macro, the same stimulus leaves `err`=0.
- `rst` low during DRAIN with `c_o_v`=1 → all outputs 0 immediately; after release, the client restarts from seq 0.
